// File: rtl/riscv_hwloop_pkg.sv
// Shared constants for the hardware-loop register bank.
//   hwlp_sel_e   : CSR readback field selector encodings (rd_sel_i)
//   HWLP_WE_*    : bit positions inside the 3-bit write-enable vector {cnt, end, start}
package riscv_hwloop_pkg;

  typedef enum logic [1:0] {
    HWLP_SEL_START = 2'd0,
    HWLP_SEL_END   = 2'd1,
    HWLP_SEL_CNT   = 2'd2,
    HWLP_SEL_NONE  = 2'd3
  } hwlp_sel_e;

  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Priority selector for the hardware-loop bank.
//   match_i : per-set match vector (bit k = set k hits its end address)
//   sel_o   : one-hot select of the lowest-index (innermost) matching set
//   valid_o : at least one set matches
module riscv_hwloop_match #(
  parameter int N_REGS = 2
) (
  input  logic [N_REGS-1:0] match_i,
  output logic [N_REGS-1:0] sel_o,
  output logic              valid_o
);

  // x & -x isolates the lowest set bit, giving the innermost loop priority.
  assign sel_o   = match_i & (~match_i + N_REGS'(1));
  assign valid_o = |match_i;

endmodule

// File: rtl/riscv_hwloop_bank.sv
// Hardware-loop register bank: N_REGS sets of {start, end, counter}.
//   clk, rst              : clock, asynchronous active-high reset
//   hwlp_we_i             : write enables {cnt, end, start} for set hwlp_regid_i
//   hwlp_*_data_i         : write data (start/end stored halfword aligned)
//   pc_i, pc_valid_i      : retiring instruction address
//   jump_o, jump_target_o : branch back to the selected loop's start
//   loop_done_o           : one-cycle pulse per set after its last iteration
//   rd_regid_i, rd_sel_i  : CSR readback select; rd_data_o is the value
//   active_o              : set counter is nonzero
module riscv_hwloop_bank
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            hwlp_we_i,
  input  logic [N_REG_BITS-1:0] hwlp_regid_i,
  input  logic [31:0]           hwlp_start_data_i,
  input  logic [31:0]           hwlp_end_data_i,
  input  logic [CNT_WIDTH-1:0]  hwlp_cnt_data_i,
  input  logic [31:0]           pc_i,
  input  logic                  pc_valid_i,
  output logic                  jump_o,
  output logic [31:0]           jump_target_o,
  output logic [N_REGS-1:0]     loop_done_o,
  input  logic [N_REG_BITS-1:0] rd_regid_i,
  input  logic [1:0]            rd_sel_i,
  output logic [31:0]           rd_data_o,
  output logic [N_REGS-1:0]     active_o
);

  logic [31:0]          start_q [N_REGS];
  logic [31:0]          end_q   [N_REGS];
  logic [CNT_WIDTH-1:0] cnt_q   [N_REGS];
  logic [N_REGS-1:0]    done_q;

  logic [N_REGS-1:0]    wr_hit;
  logic [N_REGS-1:0]    match;
  logic [N_REGS-1:0]    sel;
  logic                 sel_valid;

  // An out-of-range regid decodes to no set, so such writes are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_hit   = '0;
    match    = '0;
    active_o = '0;
    for (int k = 0; k < N_REGS; k++) begin
      wr_hit[k]   = (int'(hwlp_regid_i) == k);
      match[k]    = pc_valid_i && (pc_i == end_q[k]) && (cnt_q[k] != '0);
      active_o[k] = (cnt_q[k] != '0);
    end
  end

  riscv_hwloop_match #(.N_REGS(N_REGS)) u_match (
    .match_i (match),
    .sel_o   (sel),
    .valid_o (sel_valid)
  );

  // Uses the registered start/end, so a same-cycle write only takes effect next cycle.
  always_comb begin
    jump_o        = 1'b0;
    jump_target_o = '0;
    if (sel_valid) begin
      for (int k = 0; k < N_REGS; k++) begin
        if (sel[k] && (cnt_q[k] > CNT_WIDTH'(1))) begin
          jump_o        = 1'b1;
          jump_target_o = start_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register sets are reset, not left uninitialised: a zero counter is what keeps every loop idle.
      for (int k = 0; k < N_REGS; k++) begin
        start_q[k] <= '0;
        end_q[k]   <= '0;
        cnt_q[k]   <= '0;
      end
      done_q <= '0;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        // NOTE: state uses non-blocking assignments so every set samples the same pre-edge values.
        done_q[k] <= 1'b0;
        if (wr_hit[k] && hwlp_we_i[HWLP_WE_START]) begin
          start_q[k] <= hwlp_start_data_i & ~32'd1;
        end
        if (wr_hit[k] && hwlp_we_i[HWLP_WE_END]) begin
          end_q[k] <= hwlp_end_data_i & ~32'd1;
        end
        // A counter write overrides the decrement and suppresses the done pulse.
        // sel implies cnt_q != 0, so the decrement never wraps.
        if (wr_hit[k] && hwlp_we_i[HWLP_WE_CNT]) begin
          cnt_q[k] <= hwlp_cnt_data_i;
        end else if (sel[k]) begin
          cnt_q[k]  <= cnt_q[k] - CNT_WIDTH'(1);
          done_q[k] <= (cnt_q[k] == CNT_WIDTH'(1));
        end
      end
    end
  end

  assign loop_done_o = done_q;

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (int'(rd_regid_i) == k) begin
        case (hwlp_sel_e'(rd_sel_i))
          HWLP_SEL_START: rd_data_o = start_q[k];
          HWLP_SEL_END:   rd_data_o = end_q[k];
          HWLP_SEL_CNT:   rd_data_o = 32'(cnt_q[k]);
          default:        rd_data_o = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_bank.sv
// Scoreboard bench for riscv_hwloop_bank (N_REGS=3, CNT_WIDTH=32).
// Stimulus drives one vector per cycle just after the rising edge and queues
// the hand-computed expected outputs; a monitor pops and compares on the
// falling edge of the same cycle.
module tb_riscv_hwloop_bank;

  localparam int N_REGS = 3;
  localparam int CNT_W  = 32;
  localparam int RB     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        hwlp_we_i = '0;
  logic [RB-1:0]     hwlp_regid_i = '0;
  logic [31:0]       hwlp_start_data_i = '0;
  logic [31:0]       hwlp_end_data_i = '0;
  logic [CNT_W-1:0]  hwlp_cnt_data_i = '0;
  logic [31:0]       pc_i = '0;
  logic              pc_valid_i = 1'b0;
  logic              jump_o;
  logic [31:0]       jump_target_o;
  logic [N_REGS-1:0] loop_done_o;
  logic [RB-1:0]     rd_regid_i = '0;
  logic [1:0]        rd_sel_i = '0;
  logic [31:0]       rd_data_o;
  logic [N_REGS-1:0] active_o;

  riscv_hwloop_bank #(.N_REGS(N_REGS), .CNT_WIDTH(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_we_i         (hwlp_we_i),
    .hwlp_regid_i      (hwlp_regid_i),
    .hwlp_start_data_i (hwlp_start_data_i),
    .hwlp_end_data_i   (hwlp_end_data_i),
    .hwlp_cnt_data_i   (hwlp_cnt_data_i),
    .pc_i              (pc_i),
    .pc_valid_i        (pc_valid_i),
    .jump_o            (jump_o),
    .jump_target_o     (jump_target_o),
    .loop_done_o       (loop_done_o),
    .rd_regid_i        (rd_regid_i),
    .rd_sel_i          (rd_sel_i),
    .rd_data_o         (rd_data_o),
    .active_o          (active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        jump;
    logic [31:0] tgt;
    logic [2:0]  done;
    logic [2:0]  act;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, actual, expected);
    end
  endtask

  // Monitor: compares the outputs of the current cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, "/jump"},   32'(jump_o),      32'(e.jump));
      check({e.name, "/target"}, jump_target_o,    e.tgt);
      check({e.name, "/done"},   32'(loop_done_o), 32'(e.done));
      check({e.name, "/active"}, 32'(active_o),    32'(e.act));
      check({e.name, "/rd"},     rd_data_o,        e.rd);
    end
  end

  task automatic step(input logic r, input logic [2:0] we, input logic [1:0] rid,
                      input logic [31:0] sd, input logic [31:0] ed, input logic [31:0] cd,
                      input logic pcv, input logic [31:0] pc,
                      input logic [1:0] rdid, input logic [1:0] rsel,
                      input logic ej, input logic [31:0] et, input logic [2:0] edn,
                      input logic [2:0] eact, input logic [31:0] erd, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    hwlp_we_i         = we;
    hwlp_regid_i      = rid;
    hwlp_start_data_i = sd;
    hwlp_end_data_i   = ed;
    hwlp_cnt_data_i   = cd;
    pc_valid_i        = pcv;
    pc_i              = pc;
    rd_regid_i        = rdid;
    rd_sel_i          = rsel;
    e.name = nm; e.jump = ej; e.tgt = et; e.done = edn; e.act = eact; e.rd = erd;
    exp_q.push_back(e);
  endtask

  initial begin
    //   rst we   id sd      ed      cd  pcv pc      rid sel  jmp tgt     done    act     rd
    step(1, 3'd0, 0, 0,      0,      0,  0, 0,       0, 2,   0, 0,      3'b000, 3'b000, 0,      "reset");
    // single loop: start 0x100, end 0x110, 3 iterations
    step(0, 3'd7, 0, 32'h100, 32'h110, 3, 0, 0,      0, 2,   0, 0,      3'b000, 3'b000, 0,      "wr_set0");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h110, 0, 2,   1, 32'h100, 3'b000, 3'b001, 3,     "iter1");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h110, 0, 2,   1, 32'h100, 3'b000, 3'b001, 2,     "iter2");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h110, 0, 2,   0, 0,      3'b000, 3'b001, 1,      "iter3_last");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 2,   0, 0,      3'b001, 3'b000, 0,      "done_pulse");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 2,   0, 0,      3'b000, 3'b000, 0,      "done_once");
    // zero counter at end address: no jump, no wrap
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h110, 0, 2,   0, 0,      3'b000, 3'b000, 0,      "cnt0_match");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 2,   0, 0,      3'b000, 3'b000, 0,      "cnt0_stays");
    // nested: set0 inner, set1 outer (end written with bit0 set)
    step(0, 3'd7, 0, 32'h120, 32'h12C, 2, 0, 0,      0, 0,   0, 0,      3'b000, 3'b000, 32'h100, "wr_inner");
    step(0, 3'd7, 1, 32'h100, 32'h12D, 2, 0, 0,      0, 1,   0, 0,      3'b000, 3'b001, 32'h12C, "wr_outer");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h12C, 1, 2,   1, 32'h120, 3'b000, 3'b011, 2,     "nest_a");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h12C, 1, 2,   0, 0,      3'b000, 3'b011, 2,      "nest_b");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h12C, 0, 2,   1, 32'h100, 3'b001, 3'b010, 0,     "nest_outer");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h12C, 1, 2,   0, 0,      3'b000, 3'b010, 1,      "nest_outer_last");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       1, 2,   0, 0,      3'b010, 3'b000, 0,      "nest_done1");
    // counter write collides with final decrement: write wins, no pulse
    step(0, 3'd7, 0, 32'h200, 32'h210, 1, 0, 0,      0, 2,   0, 0,      3'b000, 3'b000, 0,      "wr_coll");
    step(0, 3'd4, 0, 0,      0,      5,  1, 32'h210, 0, 2,   0, 0,      3'b000, 3'b001, 1,      "coll");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 2,   0, 0,      3'b000, 3'b001, 5,      "coll_win");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 2,   0, 0,      3'b000, 3'b001, 5,      "coll_nopulse");
    // start write during a match uses the old start this cycle
    step(0, 3'd1, 0, 32'h300, 0,     0,  1, 32'h210, 0, 0,   1, 32'h200, 3'b000, 3'b001, 32'h200, "wr_start_match");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 0,   0, 0,      3'b000, 3'b001, 32'h300, "new_start");
    // alignment, out-of-range write and readback
    step(0, 3'd1, 1, 32'h203, 0,     0,  0, 0,       1, 0,   0, 0,      3'b000, 3'b001, 32'h100, "wr_unaligned");
    step(0, 3'd7, 3, 32'hAAA, 32'hBBB, 9, 0, 0,      1, 0,   0, 0,      3'b000, 3'b001, 32'h202, "rd_aligned");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       2, 2,   0, 0,      3'b000, 3'b001, 0,      "oob_ignored");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       3, 0,   0, 0,      3'b000, 3'b001, 0,      "rd_oob_id");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       1, 3,   0, 0,      3'b000, 3'b001, 0,      "rd_sel3");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       1, 1,   0, 0,      3'b000, 3'b001, 32'h12C, "rd_end_aligned");
    // reset mid-loop
    step(0, 3'd7, 2, 32'h400, 32'h408, 2, 0, 0,      0, 2,   0, 0,      3'b000, 3'b001, 4,      "wr_set2");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       2, 2,   0, 0,      3'b000, 3'b101, 2,      "pre_reset");
    step(1, 3'd0, 0, 0,      0,      0,  1, 32'h408, 2, 2,   0, 0,      3'b000, 3'b000, 0,      "async_reset");
    step(0, 3'd0, 0, 0,      0,      0,  1, 32'h408, 2, 0,   0, 0,      3'b000, 3'b000, 0,      "post_reset");
    step(0, 3'd0, 0, 0,      0,      0,  0, 0,       0, 0,   0, 0,      3'b000, 3'b000, 0,      "post_reset_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_bank.md
RISCV_HWLOOP_BANK -- requirements
Module: riscv_hwloop_bank

Interface
REQ-001 SHALL have parameter N_REGS, default 2: number of hardware-loop register sets, legal 1..8.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: loop counter width, legal 2..32.
REQ-003 SHALL have parameter N_REG_BITS, default max(1, clog2(N_REGS)): register-set index width.
REQ-004 SHALL have ports: clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports: hwlp_we_i  in  3  write enables {cnt, end, start}.
REQ-007 SHALL have ports: hwlp_regid_i  in  N_REG_BITS  target set for writes.
REQ-008 SHALL have ports: hwlp_start_data_i, hwlp_end_data_i  in  32 each  address write data.
REQ-009 SHALL have ports: hwlp_cnt_data_i  in  CNT_WIDTH  counter write data.
REQ-010 SHALL have ports: pc_i  in  32  address of the instruction retiring this cycle.
REQ-011 SHALL have ports: pc_valid_i  in  1  pc_i is valid and retiring.
REQ-012 SHALL have ports: jump_o  out  1  branch back to the loop start.
REQ-013 SHALL have ports: jump_target_o  out  32  branch target address.
REQ-014 SHALL have ports: loop_done_o  out  N_REGS  one-cycle pulse per set when its final iteration completes.
REQ-015 SHALL have ports: rd_regid_i  in  N_REG_BITS, rd_sel_i  in  2 (0 start, 1 end, 2 cnt), rd_data_o  out  32  CSR readback.
REQ-016 SHALL have ports: active_o  out  N_REGS  counter of the set is nonzero.

Function
REQ-017 Each set SHALL hold start_q, end_q (32 bits) and cnt_q (CNT_WIDTH bits).
REQ-018 A write SHALL update each field whose hwlp_we_i bit is set, in set hwlp_regid_i, at the next edge; fields with clear bits are unchanged.
REQ-019 Bit 0 of start and end SHALL be stored as 0 (halfword alignment).
REQ-020 A write with hwlp_regid_i >= N_REGS SHALL be ignored.
REQ-021 Set k SHALL match when pc_valid_i=1, pc_i==end_q[k] and cnt_q[k]!=0.
REQ-022 The lowest-index matching set SHALL be selected (innermost priority); other matching sets are untouched that cycle.
REQ-023 jump_o SHALL be combinational and equal to 1 iff a set is selected and its cnt_q > 1; jump_target_o is then start_q of that set, otherwise 0.
REQ-024 The selected set's cnt_q SHALL decrement by 1 at the next edge; at most one counter decrements per cycle.
REQ-025 A counter at 0 SHALL never decrement (no wrap-around).
REQ-026 If the selected set has cnt_q==1, loop_done_o[k] SHALL pulse high for exactly the cycle after the edge where cnt_q reaches 0.
REQ-027 If a counter write and a decrement target the same set in one cycle, the write SHALL win and no done pulse SHALL be generated.
REQ-028 A start/end write to a set that matches in the same cycle SHALL NOT affect that cycle's jump_o or jump_target_o; the new value is used from the next cycle.
REQ-029 rd_data_o SHALL be combinational from the current register values; cnt is zero-extended; rd_sel_i=3 or an out-of-range rd_regid_i returns 0.
REQ-030 active_o[k] SHALL be 1 iff cnt_q[k]!=0.

Reset
REQ-031 While rst=1, all start_q, end_q and cnt_q SHALL be 0 and loop_done_o SHALL be 0; consequently jump_o=0, jump_target_o=0 and active_o=0.
REQ-032 A reset asserted mid-loop SHALL clear state immediately, with no done pulse produced afterwards.

Structure
REQ-033 Package riscv_hwloop_pkg SHALL hold the rd_sel encodings (HWLP_SEL_START/END/CNT) and the we bit-index constants.
REQ-034 The priority match and selection SHALL be the sub-module riscv_hwloop_match: inputs are the per-set match vector; outputs are a one-hot select and a valid flag.

Verification
REQ-035 Write set0 {start=0x100, end=0x110, cnt=3}, then retire pc=0x110 three times -> jump_o=1, 1, 0; cnt goes 2, 1, 0; loop_done_o[0] pulses once after the third match.
REQ-036 Nested: set0 {0x120,0x12C,cnt 2}, set1 {0x100,0x12C,cnt 2}, pc=0x12C -> set0 selected, target 0x120, set1 unchanged until cnt0=0, then set1 selected.
REQ-037 cnt0=1 plus a same-cycle counter write 5 to set0 while pc=end0 -> cnt0=5, no done pulse, jump_o=0 that cycle.
REQ-038 With cnt=0 and pc=end -> jump_o=0, counter stays 0, active_o=0.
REQ-039 Write start data 0x203 -> readback via rd_sel=0 returns 0x202; write to regid>=N_REGS (N_REGS=3, regid 3) -> no state change.
REQ-040 rst asserted at cnt=2 mid-loop -> all registers 0 asynchronously, outputs 0, no loop_done_o pulse after release.
